// File: rtl/hazard_controller_if.sv
// Bundle between the rfetch/execute/memory stage registers and the
// hazard controller: match inputs, forwarding selects and pipeline control.
interface hazard_controller_if #(
    parameter int COUNT_W = 16
);
    logic                rfetch_v_i;
    logic [4:0]          rfetch_rs1_i;
    logic [4:0]          rfetch_rs2_i;
    logic                rfetch_rs1_used_i;
    logic                rfetch_rs2_used_i;
    logic                rfetch_mdu_v_i;
    logic                execute_v_i;
    logic [4:0]          execute_rd_i;
    logic                execute_wb_v_i;
    logic                execute_load_v_i;
    logic                memory_v_i;
    logic [4:0]          memory_rd_i;
    logic                memory_wb_v_i;
    logic                branch_taken_i;
    logic                mdu_done_i;
    logic                forwarding_execute_rs1_v;
    logic                forwarding_execute_rs2_v;
    logic                forwarding_memory_rs1_v;
    logic                forwarding_memory_rs2_v;
    logic                stall_o;
    logic                flush_o;
    logic                mdu_start_o;
    logic [1:0]          state_o;
    logic [COUNT_W-1:0]  stall_count_o;

    modport master (
        input  rfetch_v_i, rfetch_rs1_i, rfetch_rs2_i,
        input  rfetch_rs1_used_i, rfetch_rs2_used_i,
        input  rfetch_mdu_v_i,
        input  execute_v_i, execute_rd_i,
        input  execute_wb_v_i, execute_load_v_i,
        input  memory_v_i, memory_rd_i, memory_wb_v_i,
        input  branch_taken_i, mdu_done_i,
        output forwarding_execute_rs1_v,
        output forwarding_execute_rs2_v,
        output forwarding_memory_rs1_v,
        output forwarding_memory_rs2_v,
        output stall_o, flush_o, mdu_start_o,
        output state_o, stall_count_o
    );

    modport slave (
        output rfetch_v_i, rfetch_rs1_i, rfetch_rs2_i,
        output rfetch_rs1_used_i, rfetch_rs2_used_i,
        output rfetch_mdu_v_i,
        output execute_v_i, execute_rd_i,
        output execute_wb_v_i, execute_load_v_i,
        output memory_v_i, memory_rd_i, memory_wb_v_i,
        output branch_taken_i, mdu_done_i,
        input  forwarding_execute_rs1_v,
        input  forwarding_execute_rs2_v,
        input  forwarding_memory_rs1_v,
        input  forwarding_memory_rs2_v,
        input  stall_o, flush_o, mdu_start_o,
        input  state_o, stall_count_o
    );
endinterface

// File: rtl/hazard_controller.sv
// Execute-stage hazard controller: forwarding selects, load-use stalls,
// branch flushes and serialised MDU launch/wait.
module hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2,
    parameter int COUNT_W           = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    hazard_controller_if.master hz
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MDU_WAIT   = 2'd3
    } state_e;

    localparam int MAXC = (LOAD_STALL_CYCLES > FLUSH_CYCLES)
                        ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

    state_e              state_q;
    state_e              state_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [COUNT_W-1:0]  stall_cnt_q;

    logic exe_hit1;
    logic exe_hit2;
    logic mem_hit1;
    logic mem_hit2;
    logic exe_wr;
    logic mem_wr;
    logic hazard;
    logic branch;
    logic mdu_req;
    logic cnt_last;
    logic stall;
    logic flush;
    logic start;

    assign exe_wr = hz.execute_v_i & hz.execute_wb_v_i
                  & (hz.execute_rd_i != 5'd0);
    assign mem_wr = hz.memory_v_i & hz.memory_wb_v_i
                  & (hz.memory_rd_i != 5'd0);

    assign exe_hit1 = exe_wr & hz.rfetch_rs1_used_i
                    & (hz.execute_rd_i == hz.rfetch_rs1_i);
    assign exe_hit2 = exe_wr & hz.rfetch_rs2_used_i
                    & (hz.execute_rd_i == hz.rfetch_rs2_i);
    assign mem_hit1 = mem_wr & hz.rfetch_rs1_used_i
                    & (hz.memory_rd_i == hz.rfetch_rs1_i);
    assign mem_hit2 = mem_wr & hz.rfetch_rs2_used_i
                    & (hz.memory_rd_i == hz.rfetch_rs2_i);

    assign hazard  = hz.rfetch_v_i & hz.execute_load_v_i
                   & (exe_hit1 | exe_hit2);
    assign branch  = hz.branch_taken_i & hz.execute_v_i;
    assign mdu_req = hz.rfetch_v_i & hz.rfetch_mdu_v_i;
    assign cnt_last = (cnt_q <= CW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            RUN, LOAD_STALL: begin
                if (branch) begin
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CW'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == LOAD_STALL) begin
                    stall = 1'b1;
                    if (cnt_last) state_d = RUN;
                    else          cnt_d   = cnt_q - CW'(1);
                end else if (hazard) begin
                    stall = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = CW'(LOAD_STALL_CYCLES - 1);
                    end
                end else if (mdu_req) begin
                    start   = 1'b1;
                    stall   = 1'b1;
                    state_d = MDU_WAIT;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt_last) state_d = RUN;
                else          cnt_d   = cnt_q - CW'(1);
            end
            MDU_WAIT: begin
                if (hz.mdu_done_i) state_d = RUN;
                else               stall   = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    // Execute wins over memory; a load in execute has no result to forward yet.
    assign hz.forwarding_execute_rs1_v = rst_ni & exe_hit1
                                       & ~hz.execute_load_v_i;
    assign hz.forwarding_execute_rs2_v = rst_ni & exe_hit2
                                       & ~hz.execute_load_v_i;
    assign hz.forwarding_memory_rs1_v  = rst_ni & mem_hit1 & ~exe_hit1;
    assign hz.forwarding_memory_rs2_v  = rst_ni & mem_hit2 & ~exe_hit2;

    assign hz.stall_o       = rst_ni & stall;
    assign hz.flush_o       = rst_ni & flush;
    assign hz.mdu_start_o   = rst_ni & start;
    assign hz.state_o       = rst_ni ? state_q : 2'd0;
    assign hz.stall_count_o = rst_ni ? stall_cnt_q : '0;
endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed vectors, queued
// expectations, negedge monitor.
module tb_hazard_controller;
    logic clk;
    logic rst_n;

    hazard_controller_if #(.COUNT_W(16)) ifa ();
    hazard_controller_if #(.COUNT_W(4))  ifb ();

    hazard_controller #(
        .LOAD_STALL_CYCLES(1),
        .FLUSH_CYCLES(2),
        .COUNT_W(16)
    ) dut_a (
        .clk_i(clk),
        .rst_ni(rst_n),
        .hz(ifa)
    );

    hazard_controller #(
        .LOAD_STALL_CYCLES(3),
        .FLUSH_CYCLES(2),
        .COUNT_W(4)
    ) dut_b (
        .clk_i(clk),
        .rst_ni(rst_n),
        .hz(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic       rv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mdu;
        logic       ev;
        logic [4:0] erd;
        logic       ewb;
        logic       eld;
        logic       mv;
        logic [4:0] mrd;
        logic       mwb;
        logic       br;
        logic       done;
    } in_t;

    typedef struct {
        string       nm;
        bit          w;
        logic [3:0]  fwd;
        logic        st;
        logic        fl;
        logic        sa;
        logic [1:0]  s;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests;
    int   fails;
    int   mdl [2];

    function automatic in_t idle();
        in_t v;
        v = '{default: '0};
        v.rn = 1'b1;
        return v;
    endfunction

    function automatic in_t ld(input logic [4:0] rd,
                               input logic [4:0] rs);
        in_t v;
        v = idle();
        v.ev = 1'b1; v.ewb = 1'b1; v.eld = 1'b1; v.erd = rd;
        v.rv = 1'b1; v.rs1 = rs; v.u1 = 1'b1;
        return v;
    endfunction

    task automatic apply(input in_t v);
        rst_n = v.rn;
        ifa.rfetch_v_i = v.rv;        ifb.rfetch_v_i = v.rv;
        ifa.rfetch_rs1_i = v.rs1;     ifb.rfetch_rs1_i = v.rs1;
        ifa.rfetch_rs2_i = v.rs2;     ifb.rfetch_rs2_i = v.rs2;
        ifa.rfetch_rs1_used_i = v.u1; ifb.rfetch_rs1_used_i = v.u1;
        ifa.rfetch_rs2_used_i = v.u2; ifb.rfetch_rs2_used_i = v.u2;
        ifa.rfetch_mdu_v_i = v.mdu;   ifb.rfetch_mdu_v_i = v.mdu;
        ifa.execute_v_i = v.ev;       ifb.execute_v_i = v.ev;
        ifa.execute_rd_i = v.erd;     ifb.execute_rd_i = v.erd;
        ifa.execute_wb_v_i = v.ewb;   ifb.execute_wb_v_i = v.ewb;
        ifa.execute_load_v_i = v.eld; ifb.execute_load_v_i = v.eld;
        ifa.memory_v_i = v.mv;        ifb.memory_v_i = v.mv;
        ifa.memory_rd_i = v.mrd;      ifb.memory_rd_i = v.mrd;
        ifa.memory_wb_v_i = v.mwb;    ifb.memory_wb_v_i = v.mwb;
        ifa.branch_taken_i = v.br;    ifb.branch_taken_i = v.br;
        ifa.mdu_done_i = v.done;      ifb.mdu_done_i = v.done;
    endtask

    // One cycle of stimulus plus its hand-derived expectation.
    task automatic cyc(input string nm, input bit w, input in_t v,
                       input logic [3:0] fwd, input logic st,
                       input logic fl, input logic sa,
                       input logic [1:0] s);
        exp_t e;
        int   lim;
        lim = w ? 15 : 65535;
        @(posedge clk);
        #1;
        apply(v);
        e.nm  = nm;
        e.w   = w;
        e.fwd = v.rn ? fwd : 4'd0;
        e.st  = v.rn ? st : 1'b0;
        e.fl  = v.rn ? fl : 1'b0;
        e.sa  = v.rn ? sa : 1'b0;
        e.s   = v.rn ? s : 2'd0;
        e.cnt = v.rn ? 16'(mdl[w]) : 16'd0;
        q.push_back(e);
        if (!v.rn)                    mdl[w] = 0;
        else if (st && mdl[w] < lim)  mdl[w] = mdl[w] + 1;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [3:0]  fwd;
        logic        st, fl, sa;
        logic [1:0]  s;
        logic [15:0] cnt;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.w) begin
                fwd = {ifb.forwarding_execute_rs1_v,
                       ifb.forwarding_execute_rs2_v,
                       ifb.forwarding_memory_rs1_v,
                       ifb.forwarding_memory_rs2_v};
                st  = ifb.stall_o;
                fl  = ifb.flush_o;
                sa  = ifb.mdu_start_o;
                s   = ifb.state_o;
                cnt = 16'(ifb.stall_count_o);
            end else begin
                fwd = {ifa.forwarding_execute_rs1_v,
                       ifa.forwarding_execute_rs2_v,
                       ifa.forwarding_memory_rs1_v,
                       ifa.forwarding_memory_rs2_v};
                st  = ifa.stall_o;
                fl  = ifa.flush_o;
                sa  = ifa.mdu_start_o;
                s   = ifa.state_o;
                cnt = ifa.stall_count_o;
            end
            tests++;
            if (fwd !== e.fwd || st !== e.st || fl !== e.fl ||
                sa !== e.sa || s !== e.s || cnt !== e.cnt) begin
                fails++;
                $display("FAIL %s: got fwd=%b st=%b fl=%b sa=%b s=%0d cnt=%0d want fwd=%b st=%b fl=%b sa=%b s=%0d cnt=%0d",
                         e.nm, fwd, st, fl, sa, s, cnt,
                         e.fwd, e.st, e.fl, e.sa, e.s, e.cnt);
            end
        end
    end

    initial begin
        in_t v;
        tests = 0;
        fails = 0;
        mdl[0] = 0;
        mdl[1] = 0;
        v = idle();
        v.rn = 1'b0;
        apply(v);

        // ---- DUT A: LOAD_STALL_CYCLES=1, FLUSH_CYCLES=2 ----
        v = idle(); v.rn = 1'b0;
        v.ev = 1; v.ewb = 1; v.erd = 5; v.rv = 1; v.rs1 = 5; v.u1 = 1;
        cyc("rst0", 0, v, 4'b0000, 0, 0, 0, 0);
        cyc("rst1", 0, v, 4'b0000, 0, 0, 0, 0);
        v.rn = 1'b1;
        cyc("alu_fwd_e1", 0, v, 4'b1000, 0, 0, 0, 0);

        v = idle();
        v.ev = 1; v.ewb = 1; v.erd = 7;
        v.mv = 1; v.mwb = 1; v.mrd = 7;
        v.rv = 1; v.rs2 = 7; v.u2 = 1;
        cyc("both_rd7_rs2", 0, v, 4'b0100, 0, 0, 0, 0);
        v.erd = 0; v.mrd = 0; v.rs1 = 0; v.u1 = 1; v.rs2 = 0;
        cyc("rd0_nofwd", 0, v, 4'b0000, 0, 0, 0, 0);

        v = idle();
        v.mv = 1; v.mwb = 1; v.mrd = 9; v.rv = 1; v.rs1 = 9; v.u1 = 1;
        cyc("mem_fwd_m1", 0, v, 4'b0010, 0, 0, 0, 0);
        v.u1 = 0;
        cyc("mem_unused", 0, v, 4'b0000, 0, 0, 0, 0);

        v = ld(3, 3); v.rv = 0;
        cyc("ld_no_rv", 0, v, 4'b0000, 0, 0, 0, 0);
        v = ld(3, 3);
        cyc("ld_use", 0, v, 4'b0000, 1, 0, 0, 0);
        cyc("ld_after", 0, idle(), 4'b0000, 0, 0, 0, 0);

        v = ld(3, 3); v.mdu = 1;
        cyc("ld_over_mdu", 0, v, 4'b0000, 1, 0, 0, 0);

        v = ld(3, 3); v.br = 1;
        cyc("br_ld", 0, v, 4'b0000, 0, 1, 0, 0);
        v = idle(); v.ev = 1; v.br = 1;
        cyc("flush2", 0, v, 4'b0000, 0, 1, 0, 2);
        cyc("flush_end", 0, idle(), 4'b0000, 0, 0, 0, 0);

        v = idle(); v.done = 1;
        cyc("stray_done", 0, v, 4'b0000, 0, 0, 0, 0);

        v = idle(); v.rv = 1; v.mdu = 1;
        cyc("mdu_start", 0, v, 4'b0000, 1, 0, 1, 0);
        v.ev = 1; v.br = 1;
        for (int i = 0; i < 5; i++) begin
            cyc("mdu_wait", 0, v, 4'b0000, 1, 0, 0, 3);
        end
        v = idle(); v.done = 1;
        cyc("mdu_done", 0, v, 4'b0000, 0, 0, 0, 3);
        cyc("mdu_run", 0, idle(), 4'b0000, 0, 0, 0, 0);

        v = idle(); v.rv = 1; v.mdu = 1;
        cyc("mdu2_start", 0, v, 4'b0000, 1, 0, 1, 0);
        cyc("mdu2_wait", 0, v, 4'b0000, 1, 0, 0, 3);
        v.rn = 1'b0;
        cyc("mdu2_rst", 0, v, 4'b0000, 0, 0, 0, 0);
        cyc("mdu2_post", 0, idle(), 4'b0000, 0, 0, 0, 0);

        // ---- DUT B: LOAD_STALL_CYCLES=3, COUNT_W=4 ----
        v = idle(); v.rn = 1'b0;
        cyc("b_rst", 1, v, 4'b0000, 0, 0, 0, 0);
        cyc("b_ld0", 1, ld(3, 3), 4'b0000, 1, 0, 0, 0);
        cyc("b_ld1", 1, idle(), 4'b0000, 1, 0, 0, 1);
        cyc("b_ld2", 1, idle(), 4'b0000, 1, 0, 0, 1);
        cyc("b_ld_end", 1, idle(), 4'b0000, 0, 0, 0, 0);

        cyc("b_ld_again", 1, ld(4, 4), 4'b0000, 1, 0, 0, 0);
        v = idle(); v.ev = 1; v.br = 1;
        cyc("b_br_in_ls", 1, v, 4'b0000, 0, 1, 0, 1);
        cyc("b_flush2", 1, idle(), 4'b0000, 0, 1, 0, 2);
        cyc("b_flush_end", 1, idle(), 4'b0000, 0, 0, 0, 0);

        v = idle(); v.rv = 1; v.mdu = 1;
        cyc("b_mdu_start", 1, v, 4'b0000, 1, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cyc("b_sat_wait", 1, idle(), 4'b0000, 1, 0, 0, 3);
        end
        v = idle(); v.done = 1;
        cyc("b_sat_done", 1, v, 4'b0000, 0, 0, 0, 3);
        cyc("b_sat_hold", 1, idle(), 4'b0000, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard controller that sequences the execute-stage datapath.
- Generates the four forwarding selects consumed by execute_stage.
- Detects load-use hazards and stalls fetch/rfetch.
- Flushes wrong-path instructions after a taken branch.
- Serialises access to a shared multi-cycle multiply/divide unit (MDU) with a start/done handshake.
- Sits beside the rfetch/execute/memory pipeline registers; all inputs come from those stage registers.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1).
- FLUSH_CYCLES, 2, cycles flush_o is asserted after a taken branch (>=1).
- COUNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- rfetch_v_i  in  1  rfetch stage holds a valid instruction.
- rfetch_rs1_i / rfetch_rs2_i  in  5  source registers.
- rfetch_rs1_used_i / rfetch_rs2_used_i  in  1  source actually read.
- rfetch_mdu_v_i  in  1  rfetch instruction is an MDU op.
- execute_v_i  in  1  execute stage valid.
- execute_rd_i  in  5  destination register.
- execute_wb_v_i  in  1  writes rd.
- execute_load_v_i  in  1  is a load.
- memory_v_i  in  1  memory stage valid.
- memory_rd_i  in  5  destination register.
- memory_wb_v_i  in  1  writes rd.
- branch_taken_i  in  1  execute resolved a taken branch/jump.
- mdu_done_i  in  1  MDU result ready (1-cycle pulse).
- forwarding_execute_rs1_v / forwarding_execute_rs2_v  out  1  select execute_result.
- forwarding_memory_rs1_v / forwarding_memory_rs2_v  out  1  select memory_result.
- stall_o  out  1  hold PC/fetch/rfetch, inject bubble into execute.
- flush_o  out  1  squash fetch/rfetch contents.
- mdu_start_o  out  1  1-cycle MDU launch pulse.
- state_o  out  2  FSM state (RUN=0, LOAD_STALL=1, FLUSH=2, MDU_WAIT=3).
- stall_count_o  out  COUNT_W  saturating count of cycles with stall_o=1.

Behaviour:
- Reset: synchronous on rst_ni=0 at posedge. State=RUN, internal counters=0, stall_count_o=0. While rst_ni=0, every output is forced to 0. Reset during any state returns to RUN; an in-flight MDU op is abandoned and mdu_start_o is not reissued.
- Match definitions:
  - exe_hit(rsN) = execute_v_i & execute_wb_v_i & execute_rd_i!=0 & execute_rd_i==rfetch_rsN_i & rfetch_rsN_used_i.
  - mem_hit(rsN) = memory_v_i & memory_wb_v_i & memory_rd_i!=0 & memory_rd_i==rfetch_rsN_i & rfetch_rsN_used_i.
- Forwarding (combinational, valid in every state):
  - forwarding_execute_rsN_v = exe_hit & !execute_load_v_i.
  - forwarding_memory_rsN_v = mem_hit & !exe_hit. Execute (newer) wins. The two selects for one source are never both 1; the datapath mux gives memory priority, so this exclusion is mandatory.
- hazard = rfetch_v_i & execute_load_v_i & (exe_hit(rs1) | exe_hit(rs2)).
- Priority each cycle: branch > load hazard > MDU launch.
- RUN:
  - branch_taken_i & execute_v_i: flush_o=1 this cycle. If FLUSH_CYCLES>1, go FLUSH with counter=FLUSH_CYCLES-1. Hazard and MDU launch are suppressed.
  - Else hazard: stall_o=1 this cycle. If LOAD_STALL_CYCLES>1, go LOAD_STALL with counter=LOAD_STALL_CYCLES-1.
  - Else rfetch_v_i & rfetch_mdu_v_i: mdu_start_o=1, stall_o=1, go MDU_WAIT.
- LOAD_STALL: stall_o=1; decrement counter; go RUN when counter reaches 1. A taken branch here overrides the stall and behaves as in RUN.
- FLUSH: flush_o=1, stall_o=0; decrement counter; go RUN when counter reaches 1. Further branch_taken_i is ignored, since the pipeline holds only bubbles.
- MDU_WAIT:
  - stall_o=1 until mdu_done_i. In the done cycle stall_o=0 and the FSM returns to RUN.
  - mdu_start_o stays 0.
  - branch_taken_i is ignored, because execute holds a bubble.
- mdu_done_i outside MDU_WAIT is ignored.
- stall_count_o: +1 on each cycle with stall_o=1; saturates at all-ones with no wrap.
- Single clock domain; no combinational path from mdu_done_i to mdu_start_o.

Test Plan:
- Back-to-back ALU writes: execute_rd=5, rfetch_rs1=5, no load -> forwarding_execute_rs1_v=1, forwarding_memory_rs1_v=0, stall_o=0.
- Same rd in execute and memory (rd=7), rfetch_rs2=7 -> only forwarding_execute_rs2_v=1. Then rd=0 in both stages -> no forwarding.
- Load to x3 in execute, rfetch_rs1=3 used -> stall_o=1 for exactly 1 cycle, stall_count_o 0->1. Repeat with LOAD_STALL_CYCLES=3 -> 3 stall cycles, state_o shows 1 for 2 cycles.
- Taken branch coincident with a load hazard -> flush_o=1 for 2 cycles, stall_o=0, state_o=2 for 1 cycle.
- MDU op in rfetch -> mdu_start_o single pulse; stall_o=1 while mdu_done_i stays low for 5 cycles, then 0 in the done cycle; state RUN after.
- rst_ni low in MDU_WAIT mid-wait -> next cycle all outputs 0, state RUN. Saturation: force 2^COUNT_W stall cycles -> counter holds at all-ones.
